// File: rtl/oc8051_int_ctrl_if.sv
// Interrupt request handshake between the interrupt controller and the
// instruction-select stage.
// Signals:
//   intr  - one-cycle interrupt request (controller -> select stage)
//   int_v - vector low byte, valid from intr until ack
//   ack   - one-cycle strobe once the inserted LCALL is consumed
interface oc8051_int_ctrl_if;
    logic       intr;
    logic [7:0] int_v;
    logic       ack;

    modport master (
        output intr,
        output int_v,
        input  ack
    );

    modport slave (
        input  intr,
        input  int_v,
        output ack
    );
endinterface

// File: rtl/oc8051_int_ctrl.sv
// 8051 interrupt controller: IE/IP arbitration of five sources with
// two-level nesting, a single outstanding request, and flag-clear strobes.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   ie, ip                    - IE / IP SFR values
//   ie0, tf0, ie1, tf1, ri_ti - pending flags
//   reti                      - RETI executed strobe
//   bus                       - request handshake (intr, int_v, ack)
//   clr_ie0..clr_tf1          - one-cycle hardware clear strobes
module oc8051_int_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ie,
    input  logic [7:0] ip,
    input  logic       ie0,
    input  logic       tf0,
    input  logic       ie1,
    input  logic       tf1,
    input  logic       ri_ti,
    input  logic       reti,
    oc8051_int_ctrl_if.master bus,
    output logic       clr_ie0,
    output logic       clr_tf0,
    output logic       clr_ie1,
    output logic       clr_tf1
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       isr_hi;
    logic       isr_lo;
    logic [4:0] flags;
    logic [4:0] en;
    logic [4:0] hi_req;
    logic [4:0] lo_req;
    logic [4:0] pick;
    logic [2:0] win;
    logic       win_hi;
    logic       fire;

    // Bit index doubles as the priority rank: 0 = IE0 (highest) .. 4 = serial.
    always_comb begin
        flags  = {ri_ti, tf1, ie1, tf0, ie0};
        en     = flags & ie[4:0] & {5{ie[7]}};
        hi_req = en & ip[4:0] & {5{~isr_hi}};
        lo_req = en & ~ip[4:0] & {5{~isr_hi & ~isr_lo}};
        win_hi = |hi_req;
        pick   = win_hi ? hi_req : lo_req;
        win    = 3'd0;
        // Scan downward so the lowest set bit wins.
        for (int i = 4; i >= 0; i--) begin
            if (pick[i]) begin
                win = 3'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if ((|pick) && !reti) begin
                    fire      = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.intr  <= 1'b0;
            bus.int_v <= 8'h00;
            clr_ie0   <= 1'b0;
            clr_tf0   <= 1'b0;
            clr_ie1   <= 1'b0;
            clr_tf1   <= 1'b0;
            isr_hi    <= 1'b0;
            isr_lo    <= 1'b0;
        end else begin
            bus.intr <= fire;
            clr_ie0  <= fire && (win == 3'd0);
            clr_tf0  <= fire && (win == 3'd1);
            clr_ie1  <= fire && (win == 3'd2);
            clr_tf1  <= fire && (win == 3'd3);
            if (fire) begin
                // Vectors are 0x03 + 8*rank.
                bus.int_v <= {2'b00, win, 3'b011};
            end
            // fire is suppressed while reti is high, so these never collide.
            if (reti) begin
                if (isr_hi) begin
                    isr_hi <= 1'b0;
                end else begin
                    isr_lo <= 1'b0;
                end
            end else if (fire) begin
                if (win_hi) begin
                    isr_hi <= 1'b1;
                end else begin
                    isr_lo <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/oc8051_int_ctrl.md
# oc8051_int_ctrl

Interrupt controller for the 8051 core. It arbitrates the five standard interrupt sources by IE/IP settings and tracks two-level nesting. It issues a one-cycle interrupt request with its vector low byte to the instruction-select stage (`intr`, `int_v`) and waits for that stage's `ack` before arbitrating again. It also generates hardware-clear strobes for the edge/timer flags it vectors on.

## Interface

Parameters: none.

- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ie` in 8: IE SFR; bit7 = EA, bit4 = ES, bit3 = ET1, bit2 = EX1, bit1 = ET0, bit0 = EX0.
- `ip` in 8: IP SFR; bit4 = PS, bit3 = PT1, bit2 = PX1, bit1 = PT0, bit0 = PX0; 1 = high level.
- `ie0`, `tf0`, `ie1`, `tf1` in 1 each: pending flags from ext-int / timer logic.
- `ri_ti` in 1: serial port pending (RI|TI).
- `reti` in 1: one-cycle strobe from the decoder when RETI executes.
- `ack` in 1: one-cycle strobe from the instruction-select stage once the inserted LCALL has been consumed.
- `intr` out 1: one-cycle interrupt request.
- `int_v` out 8: vector low byte; valid from the `intr` cycle until `ack`.
- `clr_ie0`, `clr_tf0`, `clr_ie1`, `clr_tf1` out 1 each: one-cycle clear strobes to the flag owners.

## Operation

- **Source order and vectors.** Fixed order within a level: IE0 0x03 > TF0 0x0B > IE1 0x13 > TF1 0x1B > serial 0x23.
- **Enable.** A source is enabled when its flag = 1, its IE bit = 1, and EA = 1.
- **In-service registers.** `isr_hi` and `isr_lo`, 1 bit each.
- **Eligibility.**
  - High-level source: eligible iff `isr_hi` = 0.
  - Low-level source: eligible iff `isr_hi` = 0 and `isr_lo` = 0.
  - Any eligible high-level source beats all low-level sources. Within a level, fixed order applies.
- **FSM states:** IDLE, WAIT_ACK.
  - **IDLE.** If any source is eligible and `reti` = 0 this cycle, then at the next edge:
    - state becomes WAIT_ACK;
    - `intr` = 1 for that one cycle;
    - `int_v` is loaded with the winner's vector;
    - the winner's level in-service bit is set;
    - the matching `clr_*` strobe = 1 for that one cycle (none for serial; RI/TI are cleared by software).
  - **WAIT_ACK.** No arbitration. On `ack` = 1 → IDLE at the next edge; `int_v` keeps its value.
- **RETI.** Clears `isr_hi` if set, otherwise clears `isr_lo`. It is honoured in any state. In the cycle `reti` = 1, no new request is issued.
- **Registered decisions.** Arbitration uses the current-cycle inputs. Source flags, IE and IP changing after `intr` do not alter `int_v`.
- **`ack` in IDLE.** Ignored.

## Timing

- **Reset values:** `intr` = 0, `int_v` = 0x00, all `clr_*` = 0, `isr_hi` = `isr_lo` = 0, state IDLE.
- **Request latency.** Eligible source present at edge N (in IDLE, `reti` = 0) → `intr`, `clr_*` and `int_v` are valid during cycle N+1.
- **Minimum spacing.** `intr` pulses are at least 2 cycles apart: `ack` can arrive at the earliest in cycle N+1, giving IDLE in N+2 and the next `intr` in N+3.
- **Flag clear.** `clr_*` coincides with `intr`. The flag owner clears on that edge, so the flag is low by cycle N+2 and is never double-vectored.
- **`reti` and `ack` in the same cycle:** both take effect at the next edge.
- **`reti` with both in-service bits 0:** no effect.
- **Reset mid-WAIT_ACK:** returns to IDLE, clears in-service bits. A later `ack` is ignored.
- **EA dropping during WAIT_ACK:** no effect on the outstanding request.

## Test plan

- **Single source.** After reset: `ie` = 0x81, `ie0` = 1 → `intr` pulse 1 cycle later, `int_v` = 0x03, `clr_ie0` pulse in the same cycle. `ack` → IDLE. No second `intr` while `isr_lo` = 1.
- **Same-level order.** `ie` = 0x9F, `ip` = 0x00, `tf1` and `ri_ti` both set → `int_v` = 0x1B. After `ack` and `reti`, serial still pending → next `int_v` = 0x23, and no `clr_*` pulses.
- **Nesting.** Low-level TF0 in service (`int_v` = 0x0B, acked). Then `ip` = 0x04, `ie1` = 1 → `int_v` = 0x13, `isr_hi` = 1. A further `ie0` (low) is blocked until two `reti` strobes have occurred.
- **RETI guard.** `reti` asserted in the same cycle a source becomes eligible → no `intr` that cycle; `intr` appears exactly one cycle later.
- **Disabled.** EA = 0 with all flags set → `intr` stays 0 for 20 cycles.
- **Reset mid-operation.** `rst` during WAIT_ACK → all outputs at reset values next cycle. A subsequent stray `ack` produces no `intr`.
